// File: rtl/uart_mem_cmd_ctrl_pkg.sv
// uart_mem_cmd_ctrl_pkg
// Shared definitions for the UART memory debug command controller:
//   - controller state encoding
//   - bit positions inside the command header byte
//   - field offsets of the 42-bit memory read-response frame
//   - default ACK / ERR reply bytes
//   - helper that lays a response frame out as the 6 reply bytes
package uart_mem_cmd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HDR       = 3'd0,
    ST_ADDR      = 3'd1,
    ST_DATA      = 3'd2,
    ST_WAIT_EN   = 3'd3,
    ST_ISSUE     = 3'd4,
    ST_WAIT_RESP = 3'd5,
    ST_SEND      = 3'd6
  } cmd_state_t;

  // Header byte layout: {rw_flag, mem_type, 5'b0, addr[8]}
  localparam int HDR_RW_BIT    = 7;
  localparam int HDR_TYPE_BIT  = 6;
  localparam int HDR_ADDR8_BIT = 0;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  // Response frame layout: {flag, addr[8:0], data[31:0]}
  localparam int FRAME_W        = 42;
  localparam int FRAME_FLAG_BIT = 41;
  localparam int FRAME_ADDR_MSB = 40;
  localparam int FRAME_ADDR_LSB = 32;
  localparam int FRAME_DATA_MSB = 31;

  localparam int RESP_BYTES = 6;

  localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hA5;
  localparam logic [7:0] DEFAULT_ERR_BYTE = 8'hEE;

  // Reply byte order: {6'b0, flag, addr[8]}, addr[7:0], data MSB first.
  // Packed MSB-first so the serializer can shift bytes out from the top.
  function automatic logic [RESP_BYTES*8-1:0] frame_to_resp(input logic [FRAME_W-1:0] f);
    return {6'b0,
            f[FRAME_FLAG_BIT],
            f[FRAME_ADDR_MSB:FRAME_ADDR_LSB],
            f[FRAME_DATA_MSB:0]};
  endfunction

endpackage

// File: rtl/uart_mem_cmd_ctrl_resp_serializer.sv
// uart_resp_serializer
// Holds a reply (one status byte or a six-byte read response) and
// hands it to the UART transmitter one byte per valid/ready handshake.
// The byte on o_tx_byte never changes while o_tx_valid is high and
// i_tx_ready is low.
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_load_frame, i_frame  load a 42-bit read frame as six reply bytes
//   i_load_byte, i_byte    load a single reply byte
//   i_tx_ready             transmitter accepts o_tx_byte
//   o_tx_byte, o_tx_valid  byte to transmit and its valid flag
//   o_last_accept          the final byte of the reply is accepted this cycle
module uart_resp_serializer
  import uart_mem_cmd_ctrl_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load_frame,
  input  logic [FRAME_W-1:0] i_frame,
  input  logic               i_load_byte,
  input  logic [7:0]         i_byte,
  input  logic               i_tx_ready,
  output logic [7:0]         o_tx_byte,
  output logic               o_tx_valid,
  output logic               o_last_accept
);

  logic [RESP_BYTES*8-1:0] r_shift;
  logic [2:0]              r_remaining;
  logic                    w_accept;

  assign o_tx_byte     = r_shift[RESP_BYTES*8-1 -: 8];
  assign o_tx_valid    = (r_remaining != 3'd0);
  assign w_accept      = o_tx_valid && i_tx_ready;
  assign o_last_accept = w_accept && (r_remaining == 3'd1);

  // Zeros are shifted in behind the reply so tx_byte reads 0 when idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift     <= '0;
      r_remaining <= '0;
    end else if (i_load_frame) begin
      r_shift     <= frame_to_resp(i_frame);
      r_remaining <= 3'(RESP_BYTES);
    end else if (i_load_byte) begin
      r_shift     <= {i_byte, {(RESP_BYTES*8-8){1'b0}}};
      r_remaining <= 3'd1;
    end else if (w_accept) begin
      r_shift     <= r_shift << 8;
      r_remaining <= r_remaining - 3'd1;
    end
  end

endmodule

// File: rtl/uart_mem_cmd_ctrl.sv
// uart_mem_cmd_ctrl
// Turns command frames received over a UART into single debug requests
// to the data or instruction memory, and returns a reply over the UART:
// ACK_BYTE for a write, the six-byte response frame for a read.
// Requests are only issued while the CPU is halted (enable = 0).
// Optional feature macro: UART_MEM_CMD_TIMEOUT_EN
//   defined   - a partial frame is abandoned after TIMEOUT_CYCLES idle
//               cycles, an unanswered read replies ERR_BYTE instead
//   undefined - no idle counter, the controller waits indefinitely
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   rx_byte, rx_valid             bytes from the UART receiver
//   tx_byte, tx_valid, tx_ready   reply bytes to the UART transmitter
//   enable                        CPU running (stalls request issue)
//   write_mem_req, rw_flag, target_mem_type, target_addr, target_wdata
//                                 memory debug request
//   data_mem_tx_data(_ready), instr_mem_tx_data(_ready)
//                                 read responses {flag, addr, data}
//   busy                          a command is in progress
module uart_mem_cmd_ctrl
  import uart_mem_cmd_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  ACK_BYTE       = DEFAULT_ACK_BYTE,
  parameter logic [7:0]  ERR_BYTE       = DEFAULT_ERR_BYTE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_byte,
  input  logic               rx_valid,
  output logic [7:0]         tx_byte,
  output logic               tx_valid,
  input  logic               tx_ready,
  input  logic               enable,
  output logic               write_mem_req,
  output logic               rw_flag,
  output logic               target_mem_type,
  output logic [ADDR_W-1:0]  target_addr,
  output logic [DATA_W-1:0]  target_wdata,
  input  logic               data_mem_tx_data_ready,
  input  logic [FRAME_W-1:0] data_mem_tx_data,
  input  logic               instr_mem_tx_data_ready,
  input  logic [FRAME_W-1:0] instr_mem_tx_data,
  output logic               busy
);

  cmd_state_t         r_state;
  logic [1:0]         r_byteCnt;
  logic               w_respReady;
  logic [FRAME_W-1:0] w_respFrame;
  logic               w_loadFrame;
  logic               w_loadByte;
  logic [7:0]         w_replyByte;
  logic               w_lastAccept;
  logic               w_timeout;

  // Only the memory named in the header may answer; the other one's
  // ready is ignored.
  assign w_respReady = target_mem_type ? instr_mem_tx_data_ready : data_mem_tx_data_ready;
  assign w_respFrame = target_mem_type ? instr_mem_tx_data       : data_mem_tx_data;

  assign w_loadFrame = (r_state == ST_WAIT_RESP) && w_respReady;
  assign w_loadByte  = ((r_state == ST_ISSUE) && rw_flag) ||
                       ((r_state == ST_WAIT_RESP) && !w_respReady && w_timeout);
  assign w_replyByte = (r_state == ST_WAIT_RESP) ? ERR_BYTE : ACK_BYTE;

  assign busy = (r_state != ST_HDR);

`ifdef UART_MEM_CMD_TIMEOUT_EN
  logic [31:0] r_idleCnt;
  logic        w_idle;

  // A cycle counts as idle only in the states that wait on the outside
  // world and only when nothing arrived; any byte or state change
  // restarts the count.
  assign w_idle    = ((r_state == ST_ADDR) || (r_state == ST_DATA)) ? !rx_valid :
                     (r_state == ST_WAIT_RESP)                      ? !w_respReady :
                                                                      1'b0;
  assign w_timeout = w_idle && (r_idleCnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idleCnt <= '0;
    end else if (!w_idle || w_timeout) begin
      r_idleCnt <= '0;
    end else begin
      r_idleCnt <= r_idleCnt + 32'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Command FSM. Target fields are only written while a frame is being
  // received, so they stay put from WAIT_EN until the reply is sent.
  // write_mem_req is registered and high only for the single ISSUE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_HDR;
      r_byteCnt       <= '0;
      write_mem_req   <= 1'b0;
      rw_flag         <= 1'b0;
      target_mem_type <= 1'b0;
      target_addr     <= '0;
      target_wdata    <= '0;
    end else begin
      write_mem_req <= 1'b0;
      unique case (r_state)
        ST_HDR: begin
          if (rx_valid) begin
            rw_flag         <= rx_byte[HDR_RW_BIT];
            target_mem_type <= rx_byte[HDR_TYPE_BIT];
            target_addr     <= {rx_byte[HDR_ADDR8_BIT], 8'h00};
            target_wdata    <= '0;
            r_state         <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (rx_valid) begin
            target_addr[7:0] <= rx_byte;
            r_byteCnt        <= '0;
            r_state          <= rw_flag ? ST_DATA : ST_WAIT_EN;
          end else if (w_timeout) begin
            r_state <= ST_HDR;
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            target_wdata <= {target_wdata[DATA_W-9:0], rx_byte};
            r_byteCnt    <= r_byteCnt + 2'd1;
            if (r_byteCnt == 2'd3) begin
              r_state <= ST_WAIT_EN;
            end
          end else if (w_timeout) begin
            r_state <= ST_HDR;
          end
        end
        ST_WAIT_EN: begin
          if (!enable) begin
            write_mem_req <= 1'b1;
            r_state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_state <= rw_flag ? ST_SEND : ST_WAIT_RESP;
        end
        ST_WAIT_RESP: begin
          if (w_respReady || w_timeout) begin
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_lastAccept) begin
            r_state <= ST_HDR;
          end
        end
        default: begin
          r_state <= ST_HDR;
        end
      endcase
    end
  end

  uart_resp_serializer u_serializer (
    .i_clk         (clk),
    .i_rst_n       (reset),
    .i_load_frame  (w_loadFrame),
    .i_frame       (w_respFrame),
    .i_load_byte   (w_loadByte),
    .i_byte        (w_replyByte),
    .i_tx_ready    (tx_ready),
    .o_tx_byte     (tx_byte),
    .o_tx_valid    (tx_valid),
    .o_last_accept (w_lastAccept)
  );

endmodule

// File: tb/tb_uart_mem_cmd_ctrl.sv
// tb_uart_mem_cmd_ctrl
// Self-checking bench for uart_mem_cmd_ctrl. Commands are sent as byte
// frames; a queue-based model derives the expected memory request and
// reply bytes straight from the frame and response contents, and one
// negedge process checks every request and every accepted tx byte.
// With UART_MEM_CMD_TIMEOUT_EN defined the timeout scenarios also run.
module tb_uart_mem_cmd_ctrl;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] ERR = 8'hEE;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        enable;
  logic        write_mem_req;
  logic        rw_flag;
  logic        target_mem_type;
  logic [8:0]  target_addr;
  logic [31:0] target_wdata;
  logic        data_mem_tx_data_ready;
  logic [41:0] data_mem_tx_data;
  logic        instr_mem_tx_data_ready;
  logic [41:0] instr_mem_tx_data;
  logic        busy;

  typedef struct {
    logic        rw;
    logic        typ;
    logic [8:0]  addr;
    logic [31:0] wdata;
  } req_t;

  req_t       expReq[$];
  logic [7:0] expTx[$];
  int nCompared   = 0;
  int nMismatched = 0;
  int txMode      = 0;   // 0 always ready, 1 backpressure, 2 never ready

  uart_mem_cmd_ctrl #(
    .TIMEOUT_CYCLES (16),
    .ACK_BYTE       (ACK),
    .ERR_BYTE       (ERR)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .rx_byte                 (rx_byte),
    .rx_valid                (rx_valid),
    .tx_byte                 (tx_byte),
    .tx_valid                (tx_valid),
    .tx_ready                (tx_ready),
    .enable                  (enable),
    .write_mem_req           (write_mem_req),
    .rw_flag                 (rw_flag),
    .target_mem_type         (target_mem_type),
    .target_addr             (target_addr),
    .target_wdata            (target_wdata),
    .data_mem_tx_data_ready  (data_mem_tx_data_ready),
    .data_mem_tx_data        (data_mem_tx_data),
    .instr_mem_tx_data_ready (instr_mem_tx_data_ready),
    .instr_mem_tx_data       (instr_mem_tx_data),
    .busy                    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One received byte, valid for exactly one clock; called at posedge+1.
  task automatic applyStimulus(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  // Sends a full command frame and records what it must cause:
  // a request decoded from the header, plus ACK for writes.
  task automatic sendCommand(input logic [7:0] hdr, input logic [7:0] addrLo, input logic [31:0] wdata);
    req_t r;
    r.rw    = hdr[7];
    r.typ   = hdr[6];
    r.addr  = {hdr[0], addrLo};
    r.wdata = wdata;
    expReq.push_back(r);
    if (hdr[7]) expTx.push_back(ACK);
    @(posedge clk); #1;
    applyStimulus(hdr);
    applyStimulus(addrLo);
    if (hdr[7]) begin
      for (int i = 3; i >= 0; i--) applyStimulus(wdata[i*8 +: 8]);
    end
  endtask

  // Presents a read response for one cycle and records the six reply bytes.
  task automatic respond(input logic toInstr, input logic [41:0] frame);
    expTx.push_back({6'b0, frame[41:40]});
    expTx.push_back(frame[39:32]);
    for (int i = 3; i >= 0; i--) expTx.push_back(frame[i*8 +: 8]);
    @(posedge clk); #1;
    if (toInstr) begin
      instr_mem_tx_data_ready = 1'b1;
      instr_mem_tx_data       = frame;
    end else begin
      data_mem_tx_data_ready = 1'b1;
      data_mem_tx_data       = frame;
    end
    @(posedge clk); #1;
    instr_mem_tx_data_ready = 1'b0;
    data_mem_tx_data_ready  = 1'b0;
  endtask

  task automatic waitReq(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (write_mem_req) seen = 1'b1;
    end
    checkOutput("reqSeen", 64'(seen), 64'd1);
  endtask

  task automatic waitIdle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!busy && expTx.size() == 0) done = 1'b1;
    end
    checkOutput("idleReached", 64'(done), 64'd1);
    checkOutput("txDrained", 64'(expTx.size()), 64'd0);
  endtask

  // Transmitter readiness pattern: backpressure holds ready low 5 of 6 cycles.
  initial begin
    int phase = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (txMode == 0) begin
        tx_ready = 1'b1;
      end else if (txMode == 1) begin
        phase    = (phase == 5) ? 0 : phase + 1;
        tx_ready = (phase == 5);
      end else begin
        tx_ready = 1'b0;
      end
    end
  end

  // Compare process: every request against the model, every accepted
  // tx byte against the queue, and held bytes must not change.
  logic       prevHold;
  logic [7:0] prevByte;
  logic       prevReq;
  req_t       gotReq;
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("rstReq", 64'(write_mem_req), 64'd0);
      checkOutput("rstTxValid", 64'(tx_valid), 64'd0);
      prevHold = 1'b0;
      prevReq  = 1'b0;
    end else begin
      if (prevHold) begin
        checkOutput("txValidHeld", 64'(tx_valid), 64'd1);
        checkOutput("txByteHeld", 64'(tx_byte), 64'(prevByte));
      end
      if (tx_valid && tx_ready) begin
        checkOutput("txExpected", 64'(expTx.size() > 0), 64'd1);
        if (expTx.size() > 0) checkOutput("txByte", 64'(tx_byte), 64'(expTx.pop_front()));
      end
      prevHold = tx_valid && !tx_ready;
      prevByte = tx_byte;
      if (write_mem_req) begin
        checkOutput("reqOneCycle", 64'(prevReq), 64'd0);
        checkOutput("reqBusy", 64'(busy), 64'd1);
        checkOutput("reqExpected", 64'(expReq.size() > 0), 64'd1);
        if (expReq.size() > 0) begin
          gotReq = expReq.pop_front();
          checkOutput("reqRw", 64'(rw_flag), 64'(gotReq.rw));
          checkOutput("reqType", 64'(target_mem_type), 64'(gotReq.typ));
          checkOutput("reqAddr", 64'(target_addr), 64'(gotReq.addr));
          if (gotReq.rw) checkOutput("reqWdata", 64'(target_wdata), 64'(gotReq.wdata));
        end
      end
      prevReq = write_mem_req;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt;
    reset                   = 1'b0;
    rx_byte                 = 8'h00;
    rx_valid                = 1'b0;
    enable                  = 1'b0;
    data_mem_tx_data_ready  = 1'b0;
    data_mem_tx_data        = '0;
    instr_mem_tx_data_ready = 1'b0;
    instr_mem_tx_data       = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstTxByte", 64'(tx_byte), 64'd0);
    checkOutput("rstAddr", 64'(target_addr), 64'd0);
    checkOutput("rstWdata", 64'(target_wdata), 64'd0);
    checkOutput("rstRw", 64'(rw_flag), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Write 80 01 DE AD BE EF, request two cycles after the last byte
    $display("[TB] write to data addr 0x001");
    sendCommand(8'h80, 8'h01, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("latNoReqYet", 64'(write_mem_req), 64'd0);
    @(negedge clk);
    checkOutput("latReq", 64'(write_mem_req), 64'd1);
    checkOutput("wrAddrLit", 64'(target_addr), 64'h001);
    checkOutput("wrDataLit", 64'(target_wdata), 64'hDEADBEEF);
    @(negedge clk);
    checkOutput("reqDropped", 64'(write_mem_req), 64'd0);
    checkOutput("ackValid", 64'(tx_valid), 64'd1);
    checkOutput("ackByteLit", 64'(tx_byte), 64'hA5);
    waitIdle(50);

    // Read 41 23 from instruction memory; stray rx byte and data-memory
    // ready while waiting must both be ignored
    $display("[TB] read of instr addr 0x123");
    sendCommand(8'h41, 8'h23, 32'h0);
    waitReq(10);
    checkOutput("rdRwLit", 64'(rw_flag), 64'd0);
    checkOutput("rdTypeLit", 64'(target_mem_type), 64'd1);
    checkOutput("rdAddrLit", 64'(target_addr), 64'h123);
    @(posedge clk); #1;
    data_mem_tx_data_ready = 1'b1;
    data_mem_tx_data       = {1'b1, 9'h1FF, 32'hFFFFFFFF};
    rx_valid               = 1'b1;
    rx_byte                = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    data_mem_tx_data_ready = 1'b0;
    rx_valid               = 1'b0;
    rx_byte                = 8'h00;
    checkOutput("otherReadyIgnored", 64'(tx_valid), 64'd0);
    respond(1'b1, {1'b0, 9'h123, 32'h12345678});
    @(negedge clk);
    checkOutput("rdFirstByteLit", 64'(tx_byte), 64'h01);
    waitIdle(50);

    // enable held high: request stalls until the cycle after enable falls
    $display("[TB] enable stall");
    enable = 1'b1;
    sendCommand(8'hC1, 8'h80, 32'h01020304);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (write_mem_req) cnt++;
    end
    checkOutput("noReqWhileEnabled", 64'(cnt), 64'd0);
    checkOutput("busyWhileStalled", 64'(busy), 64'd1);
    @(posedge clk); #1;
    enable = 1'b0;
    @(negedge clk);
    checkOutput("stallStillNoReq", 64'(write_mem_req), 64'd0);
    @(negedge clk);
    checkOutput("stallReqAfter", 64'(write_mem_req), 64'd1);
    checkOutput("stallAddrLit", 64'(target_addr), 64'h180);
    waitIdle(50);

    // Backpressure on a data read, enable toggled while the reply is out
    $display("[TB] backpressure read of data addr 0x0AB");
    sendCommand(8'h00, 8'hAB, 32'h0);
    waitReq(10);
    enable = 1'b1;
    txMode = 1;
    respond(1'b0, {1'b1, 9'h0AB, 32'hCAFEF00D});
    @(negedge clk);
    checkOutput("bpFirstByteLit", 64'(tx_byte), 64'h02);
    waitIdle(200);
    txMode = 0;
    enable = 1'b0;

    // Reset after the third byte of a write: frame discarded
    $display("[TB] reset mid-frame");
    @(posedge clk); #1;
    applyStimulus(8'h80);
    applyStimulus(8'h01);
    applyStimulus(8'hDE);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midRstBusy", 64'(busy), 64'd0);
    checkOutput("midRstAddr", 64'(target_addr), 64'd0);
    checkOutput("midRstWdata", 64'(target_wdata), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    sendCommand(8'h00, 8'h05, 32'h0);
    waitReq(10);
    checkOutput("postRstAddrLit", 64'(target_addr), 64'h005);
    checkOutput("postRstTypeLit", 64'(target_mem_type), 64'd0);
    respond(1'b0, {1'b0, 9'h005, 32'h0BADCAFE});
    waitIdle(50);

    // Reset while the ACK is waiting for the transmitter
    $display("[TB] reset mid-send");
    txMode = 2;
    sendCommand(8'h80, 8'h10, 32'h00000001);
    cnt = 0;
    while (!tx_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("sendPendingByte", 64'(tx_byte), 64'hA5);
    @(posedge clk); #1;
    reset = 1'b0;
    expTx.delete();
    @(negedge clk);
    checkOutput("sendRstValid", 64'(tx_valid), 64'd0);
    checkOutput("sendRstBusy", 64'(busy), 64'd0);
    txMode = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    sendCommand(8'h81, 8'hFF, 32'h11223344);
    waitIdle(50);

`ifdef UART_MEM_CMD_TIMEOUT_EN
    // Unanswered read replies ERR after 16 idle cycles in WAIT_RESP
    $display("[TB] read timeout");
    sendCommand(8'h40, 8'h00, 32'h0);
    waitReq(10);
    expTx.push_back(ERR);
    cnt = 0;
    while (!tx_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("errDelayInRange", 64'(cnt >= 16 && cnt <= 18), 64'd1);
    checkOutput("errByteLit", 64'(tx_byte), 64'hEE);
    waitIdle(20);

    // Header only: silent return to HDR
    $display("[TB] header-only timeout");
    @(posedge clk); #1;
    applyStimulus(8'h80);
    @(negedge clk);
    checkOutput("hdrOnlyBusy", 64'(busy), 64'd1);
    repeat (20) @(negedge clk);
    checkOutput("hdrOnlyIdle", 64'(busy), 64'd0);
    checkOutput("hdrOnlySilent", 64'(tx_valid), 64'd0);
`endif

    repeat (3) @(negedge clk);
    checkOutput("reqQueueEmpty", 64'(expReq.size()), 64'd0);
    checkOutput("txQueueEmpty", 64'(expTx.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
